// File: rtl/tia_hphase_pkg.sv
// Shared types, LFSR helpers and decode constants for the TIA horizontal phase sequencer.
package tia_hphase_pkg;

  localparam int unsigned LFSR_W = 6;

  // Phase encoding: phi1 strobe, gap, phi2 strobe, gap/park slot.
  typedef enum logic [1:0] {
    PhPhi1 = 2'd0,
    PhGap1 = 2'd1,
    PhPhi2 = 2'd2,
    PhPark = 2'd3
  } phase_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[LFSR_W-1] ^ s[LFSR_W-2])};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_state(input int unsigned n);
    logic [LFSR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < n; i++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

  localparam logic [LFSR_W-1:0] HSYNC_START = lfsr_state(4);
  localparam logic [LFSR_W-1:0] HSYNC_END   = lfsr_state(8);
  localparam logic [LFSR_W-1:0] HBLANK_END  = lfsr_state(16);

endpackage

// File: rtl/tia_hphase_lfsr.sv
// 6-bit XNOR polynomial counter with synchronous clear, advance and wrap-to-zero.
module tia_hphase_lfsr
  import tia_hphase_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  input  logic              clear,
  input  logic              wrap,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = '0;
    end else if (advance) begin
      state_d = wrap ? '0 : lfsr_step(state);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= '0;
    end else begin
      state <= state_d;
    end
  end

endmodule

// File: rtl/tia_hphase_sequencer.sv
// Two-phase strobe generator, horizontal LFSR counter, resync handshake and halt parking.
// Optional TIA_HPHASE_DECODE_EN adds registered hsync/hblank decodes of hcount.
module tia_hphase_sequencer
  import tia_hphase_pkg::*;
#(
  parameter int unsigned PERIOD = 57
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt,
  input  logic              rsync_req,
  output logic              rsync_ack,
  output logic              phi1,
  output logic              phi2,
  output logic [LFSR_W-1:0] hcount,
  output logic              wrap
`ifdef TIA_HPHASE_DECODE_EN
  ,
  output logic              hsync,
  output logic              hblank
`endif
);

  localparam logic [LFSR_W-1:0] WRAP_STATE = lfsr_state(PERIOD - 1);

  phase_e ph_q, ph_d;
  logic   advance, clear, wrap_hit, ack_d, rsync_take;

  // Sampling is blocked while ack is high so a parked requester gets one clock to drop req.
  assign rsync_take = rsync_req && !rsync_ack;

  always_comb begin
    ph_d    = ph_q;
    advance = 1'b0;
    clear   = 1'b0;
    ack_d   = 1'b0;
    unique case (ph_q)
      PhPhi1: ph_d = PhGap1;
      PhGap1: ph_d = PhPhi2;
      PhPhi2: begin
        ph_d    = PhPark;
        advance = 1'b1;
      end
      PhPark: begin
        if (rsync_take) begin
          clear = 1'b1;
          ack_d = 1'b1;
          ph_d  = halt ? PhPark : PhPhi1;
        end else if (!halt) begin
          ph_d = PhPhi1;
        end
      end
      default: ph_d = PhPark;
    endcase
    wrap_hit = advance && (hcount == WRAP_STATE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q      <= PhPark;
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      rsync_ack <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      phi1      <= (ph_d == PhPhi1);
      phi2      <= (ph_d == PhPhi2);
      rsync_ack <= ack_d;
      wrap      <= wrap_hit;
    end
  end

  tia_hphase_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (advance),
    .clear   (clear),
    .wrap    (wrap_hit),
    .state   (hcount)
  );

`ifdef TIA_HPHASE_DECODE_EN
  logic [LFSR_W-1:0] hcount_next;

  assign hcount_next = (clear || wrap_hit) ? '0 : lfsr_step(hcount);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync  <= 1'b0;
      hblank <= 1'b0;
    end else if (clear || advance) begin
      if (hcount_next == HSYNC_START) begin
        hsync <= 1'b1;
      end else if (hcount_next == HSYNC_END) begin
        hsync <= 1'b0;
      end
      if (hcount_next == '0) begin
        hblank <= 1'b1;
      end else if (hcount_next == HBLANK_END) begin
        hblank <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tia_hphase_sequencer.sv
// Randomized self-checking bench for tia_hphase_sequencer against a line-position reference model.
module tb_tia_hphase_sequencer;

  localparam int unsigned PERIOD = 57;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       halt;
  logic       rsync_req;
  logic       rsync_ack;
  logic       phi1;
  logic       phi2;
  logic [5:0] hcount;
  logic       wrap;
`ifdef TIA_HPHASE_DECODE_EN
  logic       hsync;
  logic       hblank;
`endif

  always #5 clk = ~clk;

  tia_hphase_sequencer #(
    .PERIOD (PERIOD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .halt      (halt),
    .rsync_req (rsync_req),
    .rsync_ack (rsync_ack),
    .phi1      (phi1),
    .phi2      (phi2),
    .hcount    (hcount),
    .wrap      (wrap)
`ifdef TIA_HPHASE_DECODE_EN
    ,
    .hsync     (hsync),
    .hblank    (hblank)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference: position within the 4-clk phase cycle, and index of the line (advances since 0).
  logic [5:0] seq [PERIOD];
  int         m_pos;
  int         m_idx;
  logic       m_ack;
  logic       m_wrap;
  int         wraps_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 3;
    m_idx  = 0;
    m_ack  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("phi1", phi1, m_pos == 0);
    check_eq("phi2", phi2, m_pos == 2);
    check_eq("overlap", phi1 & phi2, 0);
    check_eq("hcount", hcount, seq[m_idx]);
    check_eq("wrap", wrap, m_wrap);
    check_eq("rsync_ack", rsync_ack, m_ack);
  endtask

  task automatic cycle();
    int   n_pos, n_idx;
    logic n_ack, n_wrap;
    n_pos  = m_pos;
    n_idx  = m_idx;
    n_ack  = 1'b0;
    n_wrap = 1'b0;
    if (m_pos == 3) begin
      if (rsync_req && !m_ack) begin
        n_idx = 0;
        n_ack = 1'b1;
        n_pos = halt ? 3 : 0;
      end else if (!halt) begin
        n_pos = 0;
      end
    end else if (m_pos == 2) begin
      n_idx  = (m_idx + 1) % PERIOD;
      n_wrap = (n_idx == 0);
      n_pos  = 3;
    end else begin
      n_pos = m_pos + 1;
    end
    @(posedge clk);
    m_pos  = n_pos;
    m_idx  = n_idx;
    m_ack  = n_ack;
    m_wrap = n_wrap;
    @(negedge clk);
    compare_all();
    if (wrap) wraps_seen++;
  endtask

  initial begin
    seq[0] = 6'b000000;
    for (int i = 1; i < PERIOD; i++) begin
      seq[i] = {seq[i-1][4:0], ~(seq[i-1][5] ^ seq[i-1][4])};
    end

    reset_n   = 1'b0;
    halt      = 1'b0;
    rsync_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // Free-running: one full line plus a little must produce exactly one wrap.
    wraps_seen = 0;
    for (int i = 0; i < 240; i++) cycle();
    check_eq("wrap_count", wraps_seen, 1);

    // Random halt bursts and a requester that usually drops req once it sees ack.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) halt = ~halt;
      if (m_ack) rsync_req = ($urandom_range(7) == 0);
      else if (!rsync_req) rsync_req = ($urandom_range(11) == 0);
      cycle();
    end

    // Mid-line reset with a pending request: immediate reset values, no ack.
    halt      = 1'b0;
    rsync_req = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    rsync_req = 1'b1;
    reset_n   = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rsync_req = 1'b0;
    reset_n   = 1'b1;
    for (int i = 0; i < 40; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
